btn_reset_conditioner: RTL and testbench

Parametrised board-input conditioner between the raw FPGA button pins and the core top level. It synchronises and debounces `NUM_BTN` button inputs, emits per-button rise/fall pulses, and sequences a stretched system reset from the asynchronous `rst` and an optional debounced reset button. The core and peripherals consume its `rst_out`, not the raw pin.

---
 rtl/btn_reset_conditioner_if.sv | 30 +++
 rtl/btn_reset_conditioner.sv | 130 +++++++++++++
 tb/tb_btn_reset_conditioner.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/btn_reset_conditioner_if.sv
// Board-side signal bundle of the button/reset conditioner: raw pins in,
// debounced levels, edge pulses and the sequenced reset out.
interface btn_reset_conditioner_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_fall;
    logic               rst_out;
    logic [7:0]         rst_count;

    modport master (
        input  btn,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output rst_out,
        output rst_count
    );

    modport slave (
        output btn,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  rst_out,
        input  rst_count
    );
endinterface

// File: rtl/btn_reset_conditioner.sv
// Synchronises and debounces raw button pins, emits rise/fall pulses and
// sequences a stretched system reset from rst and an optional reset button.
module btn_reset_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int RST_BTN_EN      = 1,
    parameter int RST_BTN         = 0,
    parameter int RST_HOLD_CYCLES = 1024
) (
    input logic                       sysclk,
    input logic                       rst,
    btn_reset_conditioner_if.master   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_LIMIT = CW'(DEBOUNCE_CYCLES - 1);
    localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(RST_HOLD_CYCLES - 1);

    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] rise_vec;
    logic [NUM_BTN-1:0] fall_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          cnt_reg;
            logic                   level_reg;
            logic                   rise_reg;
            logic                   fall_reg;
            logic                   s;

            assign s = sync_reg[SYNC_STAGES-1];

            // Any sample agreeing with the accepted level restarts the count.
            always_ff @(posedge sysclk or posedge rst) begin
                if (rst) begin
                    sync_reg  <= '0;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.btn[gi]};
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    if (s == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LIMIT) begin
                        level_reg <= s;
                        cnt_reg   <= '0;
                        rise_reg  <= s;
                        fall_reg  <= ~s;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign level_vec[gi] = level_reg;
            assign rise_vec[gi]  = rise_reg;
            assign fall_vec[gi]  = fall_reg;
        end
    endgenerate

    logic req;
    assign req = (RST_BTN_EN != 0) && level_vec[RST_BTN];

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [HW-1:0] hold_reg;
    logic          rst_out_reg;
    logic [7:0]    rst_count_reg;

    // rst_out is decoded from the next state so it moves with state_reg.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RESET;
            hold_reg      <= '0;
            rst_out_reg   <= 1'b1;
            rst_count_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    if (!req) begin
                        state_reg   <= ST_HOLD;
                        hold_reg    <= '0;
                        rst_out_reg <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (req) begin
                        state_reg   <= ST_RESET;
                        rst_out_reg <= 1'b1;
                    end else if (hold_reg == HOLD_LIMIT) begin
                        state_reg   <= ST_RUN;
                        rst_out_reg <= 1'b0;
                    end else begin
                        hold_reg <= hold_reg + HW'(1);
                    end
                end
                ST_RUN: begin
                    if (req) begin
                        state_reg   <= ST_RESET;
                        rst_out_reg <= 1'b1;
                        if (rst_count_reg != 8'hFF) begin
                            rst_count_reg <= rst_count_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg   <= ST_RESET;
                    rst_out_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.btn_level = level_vec;
    assign bus.btn_rise  = rise_vec;
    assign bus.btn_fall  = fall_vec;
    assign bus.rst_out   = rst_out_reg;
    assign bus.rst_count = rst_count_reg;
endmodule

// File: tb/tb_btn_reset_conditioner.sv
// Scoreboard bench: a sample-window reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_btn_reset_conditioner;
    localparam int NB   = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RBTN = 0;
    localparam int HOLD = 8;

    logic sysclk = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    btn_reset_conditioner_if #(.NUM_BTN(NB)) bus ();

    btn_reset_conditioner #(
        .NUM_BTN(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .RST_BTN_EN(1), .RST_BTN(RBTN), .RST_HOLD_CYCLES(HOLD)
    ) dut (
        .sysclk(sysclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
        logic          ro;
        logic [7:0]    cnt;
    } exp_t;

    exp_t          sb[$];
    logic [NB-1:0] m_dq[$];
    logic [NB-1:0] m_win[$];
    logic [NB-1:0] m_lvl;
    int            m_zero_run;
    int            m_cnt;

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.ro = 1'b1;
        return e;
    endfunction

    function automatic exp_t dut_outputs();
        return {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.rst_out, bus.rst_count};
    endfunction

    task automatic check(input string name, input exp_t exp);
        exp_t got;
        got = dut_outputs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got lvl=%b rise=%b fall=%b rst_out=%b cnt=%0d expected lvl=%b rise=%b fall=%b rst_out=%b cnt=%0d",
                     name, $time, got.lvl, got.rise, got.fall, got.ro, got.cnt,
                     exp.lvl, exp.rise, exp.fall, exp.ro, exp.cnt);
        end
    endtask

    task automatic model_reset();
        m_dq  = {};
        m_win = {};
        repeat (SYNC) m_dq.push_back('0);
        repeat (DEB) m_win.push_back('0);
        m_lvl      = '0;
        m_zero_run = 0;
        m_cnt      = 0;
    endtask

    // Level flips once the last DEB synchronised samples all disagree with it;
    // rst_out is low once the request has been idle for HOLD+1 edges.
    task automatic model_edge(input logic [NB-1:0] pin);
        exp_t          e;
        logic [NB-1:0] x;
        logic [NB-1:0] nl;
        bit            stable;
        if (m_lvl[RBTN]) begin
            if (m_zero_run > HOLD && m_cnt < 255) m_cnt++;
            m_zero_run = 0;
        end else if (m_zero_run <= HOLD) begin
            m_zero_run++;
        end
        x = m_dq.pop_front();
        m_dq.push_back(pin);
        m_win.delete(0);
        m_win.push_back(x);
        nl = m_lvl;
        for (int c = 0; c < NB; c++) begin
            stable = 1'b1;
            foreach (m_win[k]) if (m_win[k][c] == m_lvl[c]) stable = 1'b0;
            if (stable) nl[c] = ~m_lvl[c];
        end
        e.lvl  = nl;
        e.rise = nl & ~m_lvl;
        e.fall = m_lvl & ~nl;
        m_lvl  = nl;
        e.ro   = (m_zero_run <= HOLD);
        e.cnt  = 8'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic cycle(input logic [NB-1:0] b, input int n);
        repeat (n) begin
            bus.btn = b;
            @(posedge sysclk);
            model_edge(b);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        sb.delete();
        #1;
        check("async_reset", reset_exp());
        sb.push_back(reset_exp());
        repeat (n) begin
            @(posedge sysclk);
            sb.push_back(reset_exp());
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic report(input string name);
        $display("phase %-12s checks=%0d errors=%0d", name, checks, errors);
    endtask

    initial begin
        forever begin
            @(negedge sysclk);
            if (sb.size() != 0) check("scoreboard", sb.pop_front());
        end
    end

    initial begin
        logic [NB-1:0] pins;
        bus.btn = '0;
        #6;
        do_reset(3);
        cycle(2'b00, 14);
        report("power_on");

        cycle(2'b10, 10);
        cycle(2'b00, 10);
        report("clean_press");

        cycle(2'b10, 2); cycle(2'b00, 1); cycle(2'b10, 2); cycle(2'b00, 10);
        report("bounce");

        cycle(2'b01, 20);
        cycle(2'b00, 20);
        report("btn_reset");

        cycle(2'b01, 8); cycle(2'b00, 6); cycle(2'b01, 7); cycle(2'b00, 20);
        report("repress_hold");

        pins = '0;
        repeat (600) begin
            if ($urandom_range(0, 4) == 0) pins[$urandom_range(0, NB-1)] ^= 1'b1;
            cycle(pins, 1);
        end
        cycle(2'b00, 20);
        report("random");

        cycle(2'b10, 4);
        do_reset(2);
        cycle(2'b00, 16);
        report("mid_debounce");

        do_reset(1);
        cycle(2'b00, 16);
        repeat (260) begin
            cycle(2'b01, 6);
            cycle(2'b00, 16);
        end
        checks++;
        if (bus.rst_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation got rst_count=%0d expected 255", bus.rst_count);
        end
        report("saturation");

        @(negedge sysclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
